// File: rtl/call_ret_pkg.sv
// call_ret_pkg: shared types and default sizing for the call/return sequencer.
package call_ret_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_POP_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        WAIT,
        LOAD
    } state_t;

endpackage

// File: rtl/call_ret_ctrl.sv
// call_ret_ctrl: turns decoder CALL/RET into stack PUSH/POP strobes and PC reloads.
// Optional macro CALL_RET_GUARD_EN adds the nesting-depth counter and the
// sticky OVF/UNF flags; without it every CALL pushes and every RET pops.
// All outputs come straight from flops: the combinational block computes the
// next value of each output alongside the next state.
module call_ret_ctrl
    import call_ret_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int POP_LAT = DEF_POP_LAT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CALL,
    input  logic         RET,
    input  logic [W-1:0] PC,
    input  logic [W-1:0] TARGET,
    input  logic         CLR_FAULT,
    output logic         STK_PUSH,
    output logic         STK_POP,
    output logic [W-1:0] STK_VALUE,
    input  logic [W-1:0] STK_OUTPUT,
    output logic         PC_LOAD,
    output logic [W-1:0] PC_VALUE,
    output logic         BUSY,
    output logic         OVF,
    output logic         UNF
);

    localparam int CW = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           push_n, pop_n, load_n, busy_n, ovf_n, unf_n;
    logic [W-1:0]   sval_n, pval_n;
    logic           full, empty;

`ifdef CALL_RET_GUARD_EN
    localparam int DW = $clog2(DEPTH + 1);
    logic [DW-1:0]  depth, depth_n;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    // Nesting depth; saturates by construction since the guard blocks the edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) depth <= '0;
        else      depth <= depth_n;
    end
`else
    logic unused_clr;
    assign unused_clr = CLR_FAULT;
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    // Next state, next output values and counter updates.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push_n  = 1'b0;
        pop_n   = 1'b0;
        load_n  = 1'b0;
        sval_n  = '0;
        pval_n  = '0;
`ifdef CALL_RET_GUARD_EN
        depth_n = depth;
        // A fault raised in the same cycle as CLR_FAULT overrides the clear.
        ovf_n   = OVF & ~CLR_FAULT;
        unf_n   = UNF & ~CLR_FAULT;
`else
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (CALL) begin
                    if (full) begin
                        ovf_n = 1'b1;
                    end else begin
                        state_n = PUSH;
                        push_n  = 1'b1;
                        load_n  = 1'b1;
                        sval_n  = PC + 1'b1;   // wraps mod 2^W
                        pval_n  = TARGET;
                    end
                end else if (RET) begin
                    if (empty) begin
                        unf_n = 1'b1;
                    end else begin
                        state_n = POP;
                        pop_n   = 1'b1;
                    end
                end
            end
            PUSH: begin
`ifdef CALL_RET_GUARD_EN
                depth_n = depth + 1'b1;
`endif
                state_n = IDLE;
            end
            POP: begin
`ifdef CALL_RET_GUARD_EN
                depth_n = depth - 1'b1;
`endif
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(POP_LAT - 1)) begin
                    cnt_n   = '0;
                    state_n = LOAD;
                    load_n  = 1'b1;
                    pval_n  = STK_OUTPUT;   // captured on the edge ending WAIT
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOAD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            STK_PUSH  <= 1'b0;
            STK_POP   <= 1'b0;
            STK_VALUE <= '0;
            PC_LOAD   <= 1'b0;
            PC_VALUE  <= '0;
            BUSY      <= 1'b0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            STK_PUSH  <= push_n;
            STK_POP   <= pop_n;
            STK_VALUE <= sval_n;
            PC_LOAD   <= load_n;
            PC_VALUE  <= pval_n;
            BUSY      <= busy_n;
            OVF       <= ovf_n;
            UNF       <= unf_n;
        end
    end

endmodule

// File: doc/call_ret_ctrl.md
# call_ret_ctrl

Call/return sequencer sitting directly upstream of the 8-bit hardware stack. It turns decoder CALL/RET requests into single-cycle stack PUSH/POP strobes and program-counter reloads: it pushes the return address (PC+1) on CALL, and pops and restores it on RET. It also tracks nesting depth to flag overflow and underflow before the stack is corrupted.

## Interface
Parameters:
- W, 8, address/data width (PC and stack word)
- DEPTH, 16, maximum permitted call nesting
- POP_LAT, 1, cycles from the STK_POP cycle until STK_OUTPUT is valid; minimum 1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- CALL  in  1  call request from decoder, sampled in IDLE only
- RET  in  1  return request from decoder, sampled in IDLE only
- PC  in  W  current program counter
- TARGET  in  W  call destination
- CLR_FAULT  in  1  clears sticky fault flags
- STK_PUSH  out  1  push strobe to stack
- STK_POP  out  1  pop strobe to stack
- STK_VALUE  out  W  data pushed to stack
- STK_OUTPUT  in  W  popped data from stack
- PC_LOAD  out  1  one-cycle PC reload strobe
- PC_VALUE  out  W  PC reload value
- BUSY  out  1  high whenever state is not IDLE; decoder stalls
- OVF  out  1  sticky overflow flag
- UNF  out  1  sticky underflow flag

## Operation
- States: IDLE, PUSH, POP, WAIT, LOAD.
- IDLE:
  - CALL=1 → PUSH. TARGET and PC+1 are latched, with PC+1 computed mod 2^W (0xFF+1 = 0x00).
  - RET=1 (CALL=0) → POP.
  - If CALL and RET are both high, CALL wins and RET is dropped.
- PUSH, one cycle:
  - STK_PUSH=1, STK_VALUE=latched PC+1, PC_LOAD=1, PC_VALUE=latched TARGET.
  - depth increments; next state is IDLE.
- POP, one cycle: STK_POP=1, depth decrements; next state is WAIT.
- WAIT: lasts POP_LAT cycles, counted by an internal counter. STK_OUTPUT is captured on the clock edge that ends the last WAIT cycle. Next state is LOAD.
- LOAD, one cycle: PC_LOAD=1, PC_VALUE=captured value; next state is IDLE.
- Depth guard:
  - CALL with depth==DEPTH: no push, no PC_LOAD, OVF set; state stays IDLE.
  - RET with depth==0: no pop, no PC_LOAD, UNF set; state stays IDLE.
- Faults are sticky until CLR_FAULT=1 or reset. If CLR_FAULT and a new fault occur in the same cycle, the flag ends set.
- STK_PUSH and STK_POP are never high in the same cycle.
- CALL/RET arriving while BUSY are ignored; the decoder must hold them until BUSY is low.
- Depth counter width is $clog2(DEPTH+1) and never wraps.

## Timing
- Reset (rst=0, asynchronous): state IDLE, depth 0, WAIT counter 0. Every output is 0, including STK_VALUE, PC_VALUE, BUSY, OVF and UNF.
- Reset mid-operation aborts immediately. No strobe is emitted after rst deasserts, and the stack pointer is resynchronised by resetting the stack on the same rst.
- CALL sampled at edge N → STK_PUSH and PC_LOAD high during cycle N+1 → IDLE at cycle N+2. CALL throughput is 1 per 2 cycles.
- RET sampled at edge N:
  - STK_POP high in cycle N+1.
  - WAIT in cycles N+2 .. N+1+POP_LAT.
  - PC_LOAD in cycle N+2+POP_LAT.
- BUSY goes high in the cycle after acceptance and falls on the edge returning to IDLE.
- Every output is registered; there are no combinational input-to-output paths.

## Configuration
- CALL_RET_GUARD_EN defined: depth counter, overflow/underflow checks and OVF/UNF are implemented as described above.
- CALL_RET_GUARD_EN undefined:
  - no depth counter; CALL always pushes and RET always pops;
  - OVF and UNF are tied to 0 and CLR_FAULT is ignored.

## Structure
- Shared package call_ret_pkg holds:
  - the state enum (IDLE, PUSH, POP, WAIT, LOAD);
  - the default width constant (8);
  - the default DEPTH and POP_LAT constants.
- Single module; no sub-module. The WAIT counter and depth counter are inline.

## Test plan
- Reset then CALL with PC=0x12, TARGET=0x40 → cycle+1: STK_PUSH=1, STK_VALUE=0x13, PC_LOAD=1, PC_VALUE=0x40; BUSY low at cycle+2.
- CALL (PC=0x12) then RET with POP_LAT=1, stack model returning 0x13 → STK_POP at cycle+1, PC_LOAD=1 with PC_VALUE=0x13 at cycle+3.
- RET straight after reset → no STK_POP, no PC_LOAD, UNF=1. UNF holds until CLR_FAULT pulse → UNF=0.
- 16 CALLs then a 17th with DEPTH=16 → 16 pushes. 17th yields no push, no PC_LOAD, OVF=1. Then 16 RETs restore return addresses in LIFO order.
- CALL and RET high together in IDLE, PC=0xFF, TARGET=0x20 → push of 0x00, PC_VALUE=0x20, no STK_POP.
- rst asserted during WAIT of a RET → all outputs 0 immediately. No PC_LOAD after release; depth reads 0, so the next RET sets UNF.
